bnn_layer_seq: RTL and testbench

BNN_LAYER_SEQ -- requirements
Module: bnn_layer_seq

---
 rtl/bnn_pkg.sv | 15 +
 rtl/bnn_layer_seq_neuron_unit.sv | 60 ++++++
 rtl/bnn_layer_seq.sv | 184 ++++++++++++++++++
 tb/tb_bnn_layer_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the sequential binary-neural-network layer.
package bnn_pkg;

  localparam int unsigned DEF_N = 16;
  localparam int unsigned DEF_M = 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/bnn_layer_seq_neuron_unit.sv
// One binary neuron: XNOR/popcount against a weight row, compare with threshold,
// result registered one stage together with its neuron index and valid.
module neuron_unit
  import bnn_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [AW-1:0]    in_idx_i,
  input  logic [N-1:0]     act_i,
  input  logic [N-1:0]     weight_i,
  input  logic [CNT_W-1:0] thr_i,
  output logic             out_valid_o,
  output logic [AW-1:0]    out_idx_o,
  output logic             out_bit_o
);

  logic [N-1:0]     match_c;
  logic [CNT_W-1:0] cnt_c;
  logic             bit_c;

  logic             valid_q;
  logic [AW-1:0]    idx_q;
  logic             bit_q;

  assign match_c = ~(act_i ^ weight_i);

  // Count agreeing bit positions between activation and weight row.
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_c = cnt_c + CNT_W'(match_c[i]);
    end
  end

  assign bit_c = (cnt_c >= thr_i);

  // Single pipeline stage between issue and write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        idx_q <= in_idx_i;
        bit_q <= bit_c;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign out_bit_o   = bit_q;

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequential binary layer: M neurons evaluated one per cycle through a single
// time-multiplexed neuron_unit, result presented with a valid/ready handshake.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter  int unsigned N  = DEF_N,
  parameter  int unsigned M  = DEF_M,
  localparam int unsigned AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [N-1:0]     w_data,
  input  logic [CNT_W-1:0] t_data,
  input  logic             start,
  input  logic [N-1:0]     act_in,
  output logic             busy,
  output logic [M-1:0]     act_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [N-1:0]     act_q, act_d;
  logic [M-1:0]     act_out_q, act_out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Snapshot of a row overwritten on the same edge a pass starts, so the
  // pass still sees the pre-write contents of that address.
  logic             shd_vld_q, shd_vld_d;
  logic [AW-1:0]    shd_addr_q, shd_addr_d;
  logic [N-1:0]     shd_w_q, shd_w_d;
  logic [CNT_W-1:0] shd_t_q, shd_t_d;

  logic [N-1:0]     w_mem_q [M];
  logic [CNT_W-1:0] t_mem_q [M];

  logic             addr_ok_c;
  logic             wr_en_c;
  logic             issue_c;
  logic [N-1:0]     row_c;
  logic [CNT_W-1:0] thr_c;

  logic             nu_valid;
  logic [AW-1:0]    nu_idx;
  logic             nu_bit;

  assign addr_ok_c = (32'(w_addr) < M);
  assign wr_en_c   = (state_q == IDLE) && w_we && addr_ok_c;

  // Operand select for the neuron being issued, honouring the snapshot.
  always_comb begin
    row_c = w_mem_q[idx_q];
    thr_c = t_mem_q[idx_q];
    if (shd_vld_q && (shd_addr_q == idx_q)) begin
      row_c = shd_w_q;
      thr_c = shd_t_q;
    end
  end

  neuron_unit #(
    .N  (N),
    .AW (AW)
  ) u_neuron (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (issue_c),
    .in_idx_i    (idx_q),
    .act_i       (act_q),
    .weight_i    (row_c),
    .thr_i       (thr_c),
    .out_valid_o (nu_valid),
    .out_idx_o   (nu_idx),
    .out_bit_o   (nu_bit)
  );

  // Next-state and datapath control for the layer pass.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_d       = act_q;
    act_out_d   = act_out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    shd_vld_d   = shd_vld_q;
    shd_addr_d  = shd_addr_q;
    shd_w_d     = shd_w_q;
    shd_t_d     = shd_t_q;
    issue_c     = 1'b0;

    if (nu_valid) begin
      act_out_d[nu_idx] = nu_bit;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          act_d      = act_in;
          act_out_d  = '0;
          busy_d     = 1'b1;
          idx_d      = '0;
          state_d    = ISSUE;
          shd_vld_d  = wr_en_c;
          shd_addr_d = w_addr;
          shd_w_d    = w_mem_q[w_addr];
          shd_t_d    = t_mem_q[w_addr];
        end
      end
      ISSUE: begin
        issue_c = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      DRAIN: begin
        if (nu_valid && (nu_idx == LAST_IDX)) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          shd_vld_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      act_q       <= '0;
      act_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      shd_vld_q   <= 1'b0;
      shd_addr_q  <= '0;
      shd_w_q     <= '0;
      shd_t_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      act_out_q   <= act_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      shd_vld_q   <= shd_vld_d;
      shd_addr_q  <= shd_addr_d;
      shd_w_q     <= shd_w_d;
      shd_t_q     <= shd_t_d;
    end
  end

  // Weight/threshold storage, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < M; j++) begin
        w_mem_q[j] <= '0;
        t_mem_q[j] <= '0;
      end
    end else if (wr_en_c) begin
      w_mem_q[w_addr] <= w_data;
      t_mem_q[w_addr] <= t_data;
    end
  end

  assign busy      = busy_q;
  assign act_out   = act_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq (N=16, M=8).
module tb_bnn_layer_seq;

  localparam int N = 16;
  localparam int M = 8;

  logic        clk;
  logic        rst;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic [7:0]  t_data;
  logic        start;
  logic [15:0] act_in;
  logic        busy;
  logic [7:0]  act_out;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  logic [15:0] m_w [M];
  logic [7:0]  m_t [M];

  typedef struct {
    string          name;
    logic [15:0]    act;
    logic [7:0][15:0] w;
    logic [7:0][7:0]  t;
    logic [7:0]     exp;
  } vec_t;

  vec_t vecs [5];

  bnn_layer_seq #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .t_data    (t_data),
    .start     (start),
    .act_in    (act_in),
    .busy      (busy),
    .act_out   (act_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Layer result from the neuron rule: agreeing-bit count against threshold.
  function automatic logic [7:0] model(input logic [15:0] a);
    logic [7:0] r;
    for (int j = 0; j < M; j++) begin
      r[j] = ($countones(~(a ^ m_w[j])) >= int'(m_t[j]));
    end
    return r;
  endfunction

  task automatic write_row(input int addr, input logic [15:0] w, input logic [7:0] t);
    w_we   = 1'b1;
    w_addr = 3'(addr);
    w_data = w;
    t_data = t;
    step();
    w_we = 1'b0;
    m_w[addr] = w;
    m_t[addr] = t;
  endtask

  // Start a pass (out_ready high), check latency, result, one-cycle valid.
  task automatic run_pass(input logic [15:0] a, input logic [7:0] exp, input string nm);
    int n;
    n      = 0;
    start  = 1'b1;
    act_in = a;
    step();
    start = 1'b0;
    w_we  = 1'b0;
    check({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(M + 1));
    check({nm, "_act_out"}, 32'(act_out), 32'(exp));
    step();
    check({nm, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({nm, "_busy_cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    t_data    = '0;
    start     = 1'b0;
    act_in    = '0;
    out_ready = 1'b1;
    for (int j = 0; j < M; j++) begin
      m_w[j] = '0;
      m_t[j] = '0;
    end

    vecs[0].name = "all_ones";
    vecs[0].act  = 16'hFFFF;
    vecs[0].w    = {8{16'hFFFF}};
    vecs[0].t    = {8{8'd16}};
    vecs[0].exp  = 8'hFF;
    vecs[1].name = "zero_w_thr8";
    vecs[1].act  = 16'h00FF;
    vecs[1].w    = {8{16'h0000}};
    vecs[1].t    = {8{8'd8}};
    vecs[1].exp  = 8'hFF;
    vecs[2].name = "zero_w_thr9";
    vecs[2].act  = 16'h00FF;
    vecs[2].w    = {8{16'h0000}};
    vecs[2].t    = {8{8'd9}};
    vecs[2].exp  = 8'h00;
    vecs[3].name = "thr_above_n";
    vecs[3].act  = 16'h0000;
    vecs[3].w    = {8{16'h0000}};
    vecs[3].t    = {8{8'd17}};
    vecs[3].exp  = 8'h00;
    vecs[4].name = "mixed_rows";
    vecs[4].act  = 16'hA5C3;
    vecs[4].w    = {{5{16'hA5C3}}, 16'h5A3C, 16'h5A3C, 16'hA5C3};
    vecs[4].t    = {{5{8'd17}}, 8'd0, 8'd1, 8'd16};
    vecs[4].exp  = 8'h05;

    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_act_out", 32'(act_out), 32'd0);
    rst = 1'b0;
    step();

    // Table-driven directed vectors.
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < M; j++) write_row(j, vecs[v].w[j], vecs[v].t[j]);
      run_pass(vecs[v].act, vecs[v].exp, vecs[v].name);
    end

    // Back-pressure: HOLD must ignore start and writes and keep the result.
    out_ready = 1'b0;
    start     = 1'b1;
    act_in    = 16'hA5C3;
    step();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("hold_latency", 32'(n), 32'(M + 1));
    for (int k = 0; k < 5; k++) begin
      start  = 1'b1;
      act_in = 16'($urandom);
      w_we   = 1'b1;
      w_addr = 3'(k);
      w_data = 16'h0000;
      t_data = 8'd0;
      step();
      check("hold_act_out", 32'(act_out), 32'h05);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
    end
    w_we      = 1'b0;
    out_ready = 1'b1;
    step();
    check("handshake_valid", 32'(out_valid), 32'd0);
    check("handshake_busy", 32'(busy), 32'd0);
    start = 1'b0;
    step();
    check("start_in_handshake_ignored", 32'(busy), 32'd0);
    run_pass(16'hA5C3, model(16'hA5C3), "after_hold");

    // Write on the start edge: pass uses the old row, next pass the new one.
    for (int j = 0; j < M; j++) write_row(j, 16'hFFFF, 8'd16);
    w_we   = 1'b1;
    w_addr = 3'd3;
    w_data = 16'h0000;
    t_data = 8'd16;
    run_pass(16'hFFFF, 8'hFF, "start_write_old_row");
    m_w[3] = 16'h0000;
    run_pass(16'hFFFF, 8'hF7, "start_write_new_row");

    // Reset mid-pass aborts immediately and clears storage.
    for (int j = 0; j < M; j++) write_row(j, 16'hFFFF, 8'd16);
    start  = 1'b1;
    act_in = 16'hFFFF;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_act_out", 32'(act_out), 32'd0);
    step();
    rst = 1'b0;
    for (int j = 0; j < M; j++) begin
      m_w[j] = '0;
      m_t[j] = '0;
    end
    for (int k = 0; k < 12; k++) begin
      step();
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_pass(16'h1234, 8'hFF, "post_reset_thr0");

    // Randomized passes against the reference model.
    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        write_row(int'($urandom_range(0, M - 1)), 16'($urandom), 8'($urandom_range(0, 18)));
      end
      a = 16'($urandom);
      run_pass(a, model(a), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
